baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
Parametrised fractional baud-rate generator for the UART front end of the SHA1 datapath. It produces an oversample tick (`os_tick`), a bit-boundary tick (`bit_tick`) and a mid-bit sample tick (`bit_mid`). It has a runtime-programmable integer+fractional divisor, loaded through a valid/ready handshake and applied only at bit boundaries. It also has a `sync` input that re-aligns phase, used on RX start-bit detection.

Parameters:
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor (1/2^FRAC_W clk resolution).
- `OSR`, 16: oversample ticks per bit. Must be an even number ≥ 4. `OSR_W` = clog2(OSR), derived internally.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: count enable. Low freezes all counters and suppresses ticks.
- `sync` in 1: phase-realign pulse.
- `cfg_valid` in 1: new divisor offered.
- `cfg_ready` out 1: divisor can be accepted.
- `cfg_div` in DIV_W: integer divisor. Base period is cfg_div+1 clk.
- `cfg_frac` in FRAC_W: fractional addend.
- `os_tick` out 1: one-cycle oversample pulse.
- `bit_tick` out 1: one-cycle pulse at the last oversample of each bit.
- `bit_mid` out 1: one-cycle pulse at the mid-bit oversample.
- `running` out 1: a divisor is loaded and the generator is active.
- `cfg_pending` out 1: an accepted divisor is waiting for a bit boundary.

Behaviour:
- **Reset.** State IDLE. `base_cnt`, `os_cnt`, `acc`, `extend`, `div_reg`, `frac_reg`, `div_shadow`, `frac_shadow` are all 0. All tick outputs 0, `running`=0, `cfg_pending`=0, `cfg_ready`=1. A reset mid-operation aborts immediately, including any pending config.
- **States:**
  - IDLE: no ticks; `cfg_ready`=1.
  - RUN: ticking; `cfg_ready`=1.
  - PEND: ticking on the old divisor; `cfg_ready`=0.
- **IDLE accept** (`cfg_valid`&&`cfg_ready`):
  - Load `div_reg` and `frac_reg` directly.
  - Clear `base_cnt`, `os_cnt`, `acc`, `extend`.
  - Go to RUN.
- **RUN accept:** store the config into the shadow registers and go to PEND.
- **PEND:**
  - In the cycle where `bit_tick`=1, copy shadow to `div_reg`/`frac_reg`, clear `acc` and `extend`, and go to RUN.
  - The new divisor governs from the next cycle.
  - If `en` is low, PEND persists indefinitely.
- **Terminal count.** N = `div_reg` + `extend`.
  - `base_cnt` increments each cycle when (RUN or PEND) && `en`.
  - When `base_cnt`==N it wraps to 0 and `os_tick` fires (combinational, same cycle).
  - `cfg_div`=0 is legal: with `extend`=0, `os_tick` fires every enabled cycle.
- **Fractional step.** On each `os_tick`: {carry, `acc`} = `acc` + `frac_reg` (FRAC_W+1-bit add), and `extend` <= carry. Average period is `div`+1+`frac`/2^FRAC_W clk.
- **Oversample counter.** `os_cnt` increments on `os_tick`, wrapping from OSR-1 to 0.
  - `bit_tick` = `os_tick` && `os_cnt`==OSR-1.
  - `bit_mid` = `os_tick` && `os_cnt`==OSR/2-1.
- **sync** (RUN/PEND only, ignored in IDLE):
  - Clears `base_cnt`, `os_cnt`, `acc`, `extend` at the next edge.
  - All tick outputs are forced 0 in the sync cycle, so sync wins over a coincident tick.
  - With sync in cycle k, the first `os_tick` is in cycle k+1+`div_reg`, and the first `bit_mid` is OSR/2 oversample periods after sync.
  - A PEND config still waits for a real `bit_tick`.
- **en low:** counters hold, ticks are 0, and the handshake still operates (IDLE→RUN load and RUN→PEND capture proceed).
- **Status outputs:** `running` = state≠IDLE; `cfg_pending` = state==PEND.
- **Widths:** `base_cnt` is DIV_W+1 bits so N=2^DIV_W−1+1 does not overflow.

Decomposition:
- Package `uart_pkg`:
  - state enum (IDLE=0, RUN=1, PEND=2);
  - board constants CLK_HZ=100_000_000, BAUD_115200_DIV=53, BAUD_115200_FRAC=4 (FRAC_W=4);
  - OSR default.
- Sub-module `baud_frac_div`: `base_cnt`, `acc` and `extend`, with `os_tick` output and `clr`/`load` inputs.
- The top level holds the FSM, shadow registers, `os_cnt` and tick decode.

Test Plan:
1. Reset, then load `div`=3, `frac`=0, `en`=1 → `os_tick` every 4 cycles, `bit_tick` every 64, `bit_mid` at cycles 32+64k after load (os index 7), `running`=1.
2. Load `div`=53, `frac`=4 → os periods repeat 54,54,54,55; 16 os_ticks take 868 cycles (115200 baud at 100 MHz).
3. In RUN with `div`=3, offer `div`=7 mid-bit → `cfg_ready` drops, `cfg_pending`=1 until the next `bit_tick`; afterwards `os_tick` every 8 cycles, `cfg_ready`=1.
4. Assert `sync` in cycle k with `div`=3, coincident with an `os_tick` → no tick in cycle k; next `os_tick` at k+4; `bit_mid` at k+32; `bit_tick` at k+64.
5. Hold `en`=0 for 10 cycles mid-count → no ticks and counters frozen; resumes with the same remaining count. Assert `rst` during PEND → IDLE, all outputs 0, `cfg_ready`=1, pending config discarded.
6. Load `cfg_div`=0, `frac`=0 → `os_tick` every cycle. Then `frac`=8 (via PEND) → alternating 1- and 2-cycle periods.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and board constants for the UART front end.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } baud_state_e;

  localparam int unsigned CLK_HZ           = 100_000_000;
  // 100 MHz / 115200 = 868.06 clk per bit = 16 * (53 + 1 + 4/16)
  localparam int unsigned BAUD_115200_DIV  = 53;
  localparam int unsigned BAUD_115200_FRAC = 4;
  localparam int unsigned OSR_DEFAULT      = 16;

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: base counter with a one-cycle period extension
// whenever the fractional accumulator carries.
module baud_frac_div #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              squash,
  input  logic              clr,
  input  logic              load,
  input  logic [DIV_W-1:0]  div,
  input  logic [FRAC_W-1:0] frac,
  output logic              os_tick
);

  logic [DIV_W:0]  base_cnt_q, base_cnt_d;
  logic [DIV_W:0]  term_cnt;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0] acc_sum;
  logic            extend_q, extend_d;
  logic            at_term;

  always_comb begin
    term_cnt   = {1'b0, div} + {{DIV_W{1'b0}}, extend_q};
    at_term    = (base_cnt_q == term_cnt);
    os_tick    = cnt_en && at_term && !squash;
    acc_sum    = {1'b0, acc_q} + {1'b0, frac};
    base_cnt_d = base_cnt_q;
    acc_d      = acc_q;
    extend_d   = extend_q;
    if (clr) begin
      base_cnt_d = '0;
      acc_d      = '0;
      extend_d   = 1'b0;
    end else begin
      if (cnt_en) begin
        base_cnt_d = at_term ? '0 : base_cnt_q + {{DIV_W{1'b0}}, 1'b1};
      end
      // A divisor swap restarts the fractional phase from zero
      if (load) begin
        acc_d    = '0;
        extend_d = 1'b0;
      end else if (os_tick) begin
        acc_d    = acc_sum[FRAC_W-1:0];
        extend_d = acc_sum[FRAC_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_cnt_q <= '0;
      acc_q      <= '0;
      extend_q   <= 1'b0;
    end else begin
      base_cnt_q <= base_cnt_d;
      acc_q      <= acc_d;
      extend_q   <= extend_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: oversample, mid-bit and bit-boundary ticks with a
// divisor that can be reprogrammed safely at bit boundaries.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OSR    = OSR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              bit_mid,
  output logic              running,
  output logic              cfg_pending
);

  localparam int unsigned OSR_W = $clog2(OSR);

  baud_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_reg_q, div_reg_d, div_shadow_q, div_shadow_d;
  logic [FRAC_W-1:0] frac_reg_q, frac_reg_d, frac_shadow_q, frac_shadow_d;
  logic [OSR_W-1:0]  os_cnt_q, os_cnt_d;
  logic              active, cnt_en, sync_act, idle_load, swap, accept;

  baud_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (cnt_en),
    .squash  (sync_act),
    .clr     (idle_load || sync_act),
    .load    (swap),
    .div     (div_reg_q),
    .frac    (frac_reg_q),
    .os_tick (os_tick)
  );

  always_comb begin
    active      = (state_q != StIdle);
    cnt_en      = active && en;
    sync_act    = active && sync;
    running     = active;
    cfg_pending = (state_q == StPend);
    cfg_ready   = (state_q != StPend);
    accept      = cfg_valid && cfg_ready;
    bit_tick    = os_tick && (os_cnt_q == OSR_W'(OSR - 1));
    bit_mid     = os_tick && (os_cnt_q == OSR_W'(OSR / 2 - 1));

    state_d       = state_q;
    div_reg_d     = div_reg_q;
    frac_reg_d    = frac_reg_q;
    div_shadow_d  = div_shadow_q;
    frac_shadow_d = frac_shadow_q;
    idle_load     = 1'b0;
    swap          = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          div_reg_d  = cfg_div;
          frac_reg_d = cfg_frac;
          idle_load  = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          div_shadow_d  = cfg_div;
          frac_shadow_d = cfg_frac;
          state_d       = StPend;
        end
      end
      StPend: begin
        // bit_tick is already squashed by sync, so a realign never swaps
        if (bit_tick) begin
          div_reg_d  = div_shadow_q;
          frac_reg_d = frac_shadow_q;
          swap       = 1'b1;
          state_d    = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    os_cnt_d = os_cnt_q;
    if (idle_load || sync_act) begin
      os_cnt_d = '0;
    end else if (os_tick) begin
      os_cnt_d = bit_tick ? '0 : os_cnt_q + OSR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      div_reg_q     <= '0;
      frac_reg_q    <= '0;
      div_shadow_q  <= '0;
      frac_shadow_q <= '0;
      os_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      div_reg_q     <= div_reg_d;
      frac_reg_q    <= frac_reg_d;
      div_shadow_q  <= div_shadow_d;
      frac_shadow_q <= frac_shadow_d;
      os_cnt_q      <= os_cnt_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: expected tick cycles are queued when a
// divisor is programmed and consumed as the ticks appear.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div = '0;
  logic [3:0]  cfg_frac = '0;
  logic        os_tick, bit_tick, bit_mid, running, cfg_pending;

  baud_tick_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_frac    (cfg_frac),
    .os_tick     (os_tick),
    .bit_tick    (bit_tick),
    .bit_mid     (bit_mid),
    .running     (running),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;
  int os_q[$];
  int bit_q[$];
  int mid_q[$];
  int os_hist[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected tick cycles for a divisor taking effect at the end of cycle start.
  task automatic push_ticks(input int start, input int div, input int frac, input int n,
                            input int idx0, output int last);
    int t, e, acc, idx, s;
    t = start; e = 0; acc = 0; idx = idx0;
    for (int i = 0; i < n; i++) begin
      t = t + div + 1 + e;
      os_q.push_back(t);
      if (idx == 15) bit_q.push_back(t);
      if (idx == 7) mid_q.push_back(t);
      idx = (idx + 1) % 16;
      s   = acc + frac;
      acc = s % 16;
      e   = s / 16;
    end
    last = t;
  endtask

  task automatic offer(input int d, input int f, output int c);
    cfg_div = 16'(d);
    cfg_frac = 4'(f);
    cfg_valid = 1'b1;
    c = cyc;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_until(input int l);
    while (cyc <= l) step(1);
    mon_on = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_os_left"}, os_q.size(), 0);
    check({tag, "_bit_left"}, bit_q.size(), 0);
    check({tag, "_mid_left"}, mid_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    sync = 1'b0;
    cfg_valid = 1'b0;
    os_q.delete(); bit_q.delete(); mid_q.delete(); os_hist.delete();
    step(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (os_tick) begin
        os_hist.push_back(cyc);
        if (os_q.size() == 0) check("os_unexpected", int'(os_tick), 0);
        else check("os_tick_cycle", cyc, os_q.pop_front());
      end
      if (bit_tick) begin
        if (bit_q.size() == 0) check("bit_unexpected", int'(bit_tick), 0);
        else check("bit_tick_cycle", cyc, bit_q.pop_front());
      end
      if (bit_mid) begin
        if (mid_q.size() == 0) check("mid_unexpected", int'(bit_mid), 0);
        else check("bit_mid_cycle", cyc, mid_q.pop_front());
      end
    end
  end

  initial begin
    int c, c2, k, l, last;

    // Reset state, then div=3 frac=0
    do_reset();
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_running", int'(running), 0);
    check("rst_pending", int'(cfg_pending), 0);
    check("rst_os_tick", int'(os_tick), 0);
    check("rst_bit_tick", int'(bit_tick), 0);
    check("rst_bit_mid", int'(bit_mid), 0);
    en = 1'b1;
    offer(3, 0, c);
    check("p1_running", int'(running), 1);
    check("p1_cfg_ready", int'(cfg_ready), 1);
    push_ticks(c, 3, 0, 128, 0, last);
    mon_on = 1'b1;
    wait_until(last);
    check_drained("p1");

    // 115200 baud divisor: 54,54,54,55 pattern
    do_reset();
    en = 1'b1;
    offer(53, 4, c);
    push_ticks(c, 53, 4, 17, 0, last);
    mon_on = 1'b1;
    wait_until(last);
    check_drained("p2");
    check("p2_hist_size", os_hist.size(), 17);
    if (os_hist.size() >= 17) begin
      check("p2_span16", os_hist[16] - os_hist[0], 868);
      check("p2_period5", os_hist[4] - os_hist[3], 55);
    end

    // Mid-bit reprogram 3 -> 7, applied at the next bit boundary
    do_reset();
    en = 1'b1;
    offer(3, 0, c);
    push_ticks(c, 3, 0, 16, 0, l);
    push_ticks(c + 64, 7, 0, 16, 0, last);
    mon_on = 1'b1;
    while (cyc < c + 20) step(1);
    offer(7, 0, c2);
    check("p3_ready_low", int'(cfg_ready), 0);
    check("p3_pending", int'(cfg_pending), 1);
    while (cyc < c + 64) step(1);
    check("p3_pending_at_bit", int'(cfg_pending), 1);
    step(1);
    check("p3_pending_clr", int'(cfg_pending), 0);
    check("p3_ready_back", int'(cfg_ready), 1);
    wait_until(last);
    check_drained("p3");

    // sync coincident with an os_tick
    do_reset();
    en = 1'b1;
    offer(3, 0, c);
    push_ticks(c, 3, 0, 4, 0, l);
    k = c + 20;
    push_ticks(k, 3, 0, 16, 0, last);
    mon_on = 1'b1;
    while (cyc < k) step(1);
    sync = 1'b1;
    @(negedge clk);
    check("p4_sync_os_tick", int'(os_tick), 0);
    @(posedge clk);
    #1;
    sync = 1'b0;
    wait_until(last);
    check_drained("p4");

    // en low for 10 cycles mid-count, then reset while a config is pending
    do_reset();
    en = 1'b1;
    offer(3, 0, c);
    push_ticks(c, 3, 0, 2, 0, l);
    push_ticks(c + 18, 3, 0, 20, 2, last);
    mon_on = 1'b1;
    while (cyc < c + 10) step(1);
    en = 1'b0;
    step(5);
    check("p5_running_en_low", int'(running), 1);
    step(5);
    en = 1'b1;
    wait_until(last);
    check_drained("p5");
    offer(7, 0, c2);
    check("p5_pending", int'(cfg_pending), 1);
    rst = 1'b1;
    #1;
    check("p5_rst_running", int'(running), 0);
    check("p5_rst_pending", int'(cfg_pending), 0);
    check("p5_rst_ready", int'(cfg_ready), 1);
    check("p5_rst_os_tick", int'(os_tick), 0);
    step(2);
    rst = 1'b0;
    mon_on = 1'b1;
    step(100);
    mon_on = 1'b0;
    check("p5_idle_after_rst", int'(running), 0);

    // div=0: tick every cycle, then frac=8 gives alternating 1/2 periods
    do_reset();
    en = 1'b1;
    offer(0, 0, c);
    push_ticks(c, 0, 0, 16, 0, l);
    push_ticks(c + 16, 0, 8, 30, 0, last);
    mon_on = 1'b1;
    while (cyc < c + 3) step(1);
    offer(0, 8, c2);
    check("p6_pending", int'(cfg_pending), 1);
    wait_until(last);
    check_drained("p6");
    check("p6_hist_size", os_hist.size(), 46);
    if (os_hist.size() >= 20) begin
      check("p6_period_short", os_hist[17] - os_hist[16], 1);
      check("p6_period_long", os_hist[18] - os_hist[17], 2);
      check("p6_period_alt", os_hist[19] - os_hist[18], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
